// File: rtl/regfile_wb_driver_if.sv
// Writeback request, register file write port and forwarding lookup bundle
// shared between the datapath (master) and the writeback driver (slave).
interface regfile_wb_driver_if #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_data;
  logic          wreg;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [AW-1:0] fwd_raddr1;
  logic [AW-1:0] fwd_raddr2;
  logic          fwd_hit1;
  logic [DW-1:0] fwd_data1;
  logic          fwd_hit2;
  logic [DW-1:0] fwd_data2;
  logic [CW-1:0] pending;
  logic          idle;

  modport master (
    output in_valid, in_addr, in_data, fwd_raddr1, fwd_raddr2,
    input  in_ready, wreg, waddr, wdata, fwd_hit1, fwd_data1,
           fwd_hit2, fwd_data2, pending, idle
  );

  modport slave (
    input  in_valid, in_addr, in_data, fwd_raddr1, fwd_raddr2,
    output in_ready, wreg, waddr, wdata, fwd_hit1, fwd_data1,
           fwd_hit2, fwd_data2, pending, idle
  );
endinterface

// File: rtl/regfile_wb_driver.sv
// Writeback driver: queues results in a small FIFO, retires one register file
// write per cycle and forwards still-pending values to decode.
module regfile_wb_driver #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input logic              clk,
  input logic              resetn,
  regfile_wb_driver_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] addr_mem_q [DEPTH];
  logic [DW-1:0] data_mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          wreg_q, wreg_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [DW-1:0] wdata_q, wdata_d;

  logic          ready_s;
  logic          push_s;
  logic          pop_s;
  logic [AW-1:0] fwd_raddr_s [2];
  logic          fwd_hit_s   [2];
  logic [DW-1:0] fwd_data_s  [2];

  // A full FIFO never accepts, even when it is popping in the same cycle.
  assign ready_s = !resetn && (count_q < CW'(DEPTH));
  assign push_s  = bus.in_valid && ready_s && (bus.in_addr != {AW{1'b0}});
  assign pop_s   = (count_q != {CW{1'b0}});

  // Next-state for pointers, occupancy and the write-port output register.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    wreg_d   = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    if (pop_s) begin
      wreg_d   = 1'b1;
      waddr_d  = addr_mem_q[rd_ptr_q];
      wdata_d  = data_mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      wreg_d   = 1'b0;
    end
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (resetn) begin
      rd_ptr_q <= {PW{1'b0}};
      wr_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
      wreg_q   <= 1'b0;
      waddr_q  <= {AW{1'b0}};
      wdata_q  <= {DW{1'b0}};
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      wreg_q   <= wreg_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
    end
  end

  // FIFO storage; contents are meaningful only between the pointers.
  always_ff @(posedge clk) begin
    if (push_s) begin
      addr_mem_q[wr_ptr_q] <= bus.in_addr;
      data_mem_q[wr_ptr_q] <= bus.in_data;
    end
  end

  assign fwd_raddr_s[0] = bus.fwd_raddr1;
  assign fwd_raddr_s[1] = bus.fwd_raddr2;

  // Forwarding search: output register first, then FIFO oldest to youngest so the youngest match wins.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      fwd_hit_s[p]  = 1'b0;
      fwd_data_s[p] = {DW{1'b0}};
      if (wreg_q && (waddr_q == fwd_raddr_s[p])) begin
        fwd_hit_s[p]  = 1'b1;
        fwd_data_s[p] = wdata_q;
      end else begin
        fwd_hit_s[p]  = 1'b0;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if ((CW'(i) < count_q) &&
            (addr_mem_q[rd_ptr_q + PW'(i)] == fwd_raddr_s[p])) begin
          fwd_hit_s[p]  = 1'b1;
          fwd_data_s[p] = data_mem_q[rd_ptr_q + PW'(i)];
        end else begin
          fwd_hit_s[p]  = fwd_hit_s[p];
        end
      end
      if (fwd_raddr_s[p] == {AW{1'b0}}) begin
        fwd_hit_s[p]  = 1'b0;
        fwd_data_s[p] = {DW{1'b0}};
      end else begin
        fwd_hit_s[p]  = fwd_hit_s[p];
      end
    end
  end

  assign bus.in_ready  = ready_s;
  assign bus.wreg      = wreg_q;
  assign bus.waddr     = waddr_q;
  assign bus.wdata     = wdata_q;
  assign bus.fwd_hit1  = fwd_hit_s[0];
  assign bus.fwd_data1 = fwd_data_s[0];
  assign bus.fwd_hit2  = fwd_hit_s[1];
  assign bus.fwd_data2 = fwd_data_s[1];
  assign bus.pending   = count_q;
  assign bus.idle      = (count_q == {CW{1'b0}}) && !wreg_q;
endmodule

// File: doc/regfile_wb_driver.md
Name: regfile_wb_driver

Overview:
- Writeback-side driver for the 32x32 register file write port (wreg/waddr/wdata). It is the producer end of the port that the decode stage reads.
- Buffers writeback requests from the multi-cycle datapath (ALU, load, link) in a small FIFO. It retires at most one write per cycle into the register file.
- Provides a forwarding lookup so decode sees results that are still pending, either queued or in flight on the write port.

Parameters:
DEPTH, 4, FIFO entries (power of 2, >=2)
AW, 5, register address width
DW, 32, register data width

Ports:
clk  input  1  system clock, all state on rising edge
resetn  input  1  synchronous, active-high reset (asserted = 1)
in_valid  input  1  writeback request valid
in_ready  output  1  request can be accepted this cycle
in_addr  input  AW  destination register
in_data  input  DW  result value
wreg  output  1  register file write enable (registered)
waddr  output  AW  register file write address (registered)
wdata  output  DW  register file write data (registered)
fwd_raddr1  input  AW  decode read address 1
fwd_raddr2  input  AW  decode read address 2
fwd_hit1  output  1  pending write exists for fwd_raddr1
fwd_data1  output  DW  newest pending value for fwd_raddr1
fwd_hit2  output  1  same for port 2
fwd_data2  output  DW  same for port 2
pending  output  clog2(DEPTH)+1  number of queued FIFO entries (excludes in-flight write)
idle  output  1  pending==0 and wreg==0

Behaviour:
- Reset: resetn=1 at a rising edge clears count, read/write pointers, wreg, waddr and wdata to 0.
  - While resetn=1: in_ready=0, and any in_valid is ignored.
  - Reset mid-operation discards all queued entries and drops wreg on the next edge. No partial write is issued.
- Accept: handshake completes when in_valid && in_ready.
  - in_ready = (count < DEPTH). A full FIFO does not pass through in the same cycle, even if it pops that cycle.
- r0 filter: an accepted request with in_addr==0 completes the handshake but is not enqueued. count and outputs are unchanged.
- Simultaneous push and pop: both occur. count is unchanged, and order is preserved.
- Retire: on each edge, if count>0, the head is popped into the output register (wreg<=1, waddr/wdata<=head). Otherwise wreg<=0.
  - waddr/wdata hold their last values when wreg=0.
- Latency:
  - A request accepted at edge N into an empty FIFO appears on wreg/waddr/wdata after edge N+1.
  - The register file stores it at edge N+2.
  - Throughput is 1 write per cycle sustained.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH. No overflow or underflow is possible by construction.
- Forwarding is combinational from fwd_raddrX and state. Search set is the valid FIFO entries plus the output register when wreg=1.
  - Priority: youngest FIFO entry (nearest tail) first, then older entries, then the output register.
  - Same-cycle incoming in_* is NOT included.
  - fwd_raddrX==0: hit=0, data=0.
  - No match: hit=0, data=0.
- Multiple queued writes to the same address are all retired in order. The last one wins in the register file, consistent with forwarding priority.

Test Plan:
- Reset, then single write: accept (addr 5, 32'h1) at edge 1 -> wreg=1, waddr=5, wdata=32'h1 during cycle after edge 2. wreg=0 after edge 3. idle=1 afterwards.
- Fill and stall: hold in_valid with addr 1..6 and data 32'h10*k. Pop is blocked only by design latency.
  - in_ready=0 when pending==4.
  - No request is lost.
  - wreg sequence is addrs 1..6 in order.
- r0 drop: send (0, 32'hDEAD) then (7, 32'h7) -> handshake completes for both, only addr 7 is written, pending never counts the r0 request.
- Forwarding priority: queue (6, 32'h10) then (6, 32'h20) while output register holds (6, 32'h5) -> fwd_raddr1=6 gives hit1=1, data1=32'h20.
  - fwd_raddr2=0 gives hit2=0, data2=0.
  - After both retire, hit1=0.
- Push and pop together: steady stream of 1 request/cycle -> pending stays at 1, and wreg stays high every cycle after the first write.
- Reset mid-operation: 3 entries queued, assert resetn=1 for one edge -> pending=0 and wreg=0 after that edge. No further writes are issued. in_ready=0 during reset and 1 after.
